// File: rtl/alu_1_pipe.sv
// alu_1_pipe: per-stage RMT action ALU with configurable latency.
// One PHV container result per accepted action. The result and its carry/
// borrow flag are computed combinationally from the inputs, captured into the
// first pipeline register and shifted through LATENCY-1 further registers.
// A stalled output (valid & ~ready) freezes every stage, bubbles included.
module alu_1_pipe #(
  parameter int STAGE      = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int IMM_WIDTH  = 16,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid,
  output logic                  action_ready,
  input  logic [DATA_WIDTH-1:0] operand_1_in,
  input  logic [DATA_WIDTH-1:0] operand_2_in,
  output logic [DATA_WIDTH-1:0] container_out,
  output logic                  container_out_valid,
  input  logic                  container_out_ready,
  output logic                  flag_out
);

  localparam int DW = DATA_WIDTH;

  // Opcode encodings
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_ADD2 = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SUB2 = 4'b1010;
  localparam logic [3:0] OP_ADDI = 4'b0011;
  localparam logic [3:0] OP_SUBI = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SADD = 4'b1011;
  localparam logic [3:0] OP_SSUB = 4'b1100;

  logic          stall;
  logic          accept;
  logic [3:0]    opcode;
  logic [DW-1:0] imm_ext;
  logic [DW:0]   sum_ext;
  logic [DW:0]   diff_ext;
  logic [DW:0]   sumi_ext;
  logic [DW:0]   diffi_ext;
  logic [DW-1:0] result_next;
  logic          flag_next;

  logic [DW-1:0]      data_reg [LATENCY];
  logic [LATENCY-1:0] valid_reg;
  logic [LATENCY-1:0] flag_reg;

  // Handshake: only a held, unconsumed output blocks the pipeline.
  assign stall        = container_out_valid & ~container_out_ready;
  assign action_ready = ~stall;
  assign accept       = action_valid & action_ready;

  assign opcode  = action_in[ACTION_LEN-1 -: 4];
  assign imm_ext = DW'(action_in[IMM_WIDTH-1:0]);

  // One extra bit on every add/sub: its top bit is the carry (add) or the
  // borrow (sub, set when the difference wrapped below zero).
  assign sum_ext   = {1'b0, operand_1_in} + {1'b0, operand_2_in};
  assign diff_ext  = {1'b0, operand_1_in} - {1'b0, operand_2_in};
  assign sumi_ext  = {1'b0, operand_1_in} + {1'b0, imm_ext};
  assign diffi_ext = {1'b0, operand_1_in} - {1'b0, imm_ext};

  // Stage-0 result select; unknown opcodes pass operand 1 through.
  always_comb begin
    result_next = operand_1_in;
    flag_next   = 1'b0;
    case (opcode)
      OP_ADD, OP_ADD2: begin
        result_next = sum_ext[DW-1:0];
        flag_next   = sum_ext[DW];
      end
      OP_SUB, OP_SUB2: begin
        result_next = diff_ext[DW-1:0];
        flag_next   = diff_ext[DW];
      end
      OP_ADDI: begin
        result_next = sumi_ext[DW-1:0];
        flag_next   = sumi_ext[DW];
      end
      OP_SUBI: begin
        result_next = diffi_ext[DW-1:0];
        flag_next   = diffi_ext[DW];
      end
      OP_AND: result_next = operand_1_in & operand_2_in;
      OP_OR:  result_next = operand_1_in | operand_2_in;
      OP_XOR: result_next = operand_1_in ^ operand_2_in;
      OP_SADD: begin
        result_next = sum_ext[DW] ? '1 : sum_ext[DW-1:0];
        flag_next   = sum_ext[DW];
      end
      OP_SSUB: begin
        result_next = diff_ext[DW] ? '0 : diff_ext[DW-1:0];
        flag_next   = diff_ext[DW];
      end
      default: begin
        result_next = operand_1_in;
        flag_next   = 1'b0;
      end
    endcase
  end

  // Pipeline shift register: capture stage 0, shift the rest, hold on stall.
  // Cycles without an accept inject zeroed bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      flag_reg  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_reg[i] <= '0;
      end
    end else if (!stall) begin
      valid_reg[0] <= accept;
      flag_reg[0]  <= accept & flag_next;
      data_reg[0]  <= accept ? result_next : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        flag_reg[i]  <= flag_reg[i-1];
        data_reg[i]  <= data_reg[i-1];
      end
    end
  end

  assign container_out       = data_reg[LATENCY-1];
  assign container_out_valid = valid_reg[LATENCY-1];
  assign flag_out            = flag_reg[LATENCY-1];

  // STAGE is informational and the action bits between the immediate and the
  // opcode carry no meaning here; fold them into a deliberately unused sink.
  if (ACTION_LEN - 4 > IMM_WIDTH) begin : g_spare_bits
    logic unused_bits;
    assign unused_bits = ^{32'(STAGE), action_in[ACTION_LEN-5:IMM_WIDTH]};
  end else begin : g_no_spare_bits
    logic unused_bits;
    assign unused_bits = ^32'(STAGE);
  end

endmodule

// File: tb/tb_alu_1_pipe.sv
// tb_alu_1_pipe: directed and randomized checks of alu_1_pipe.
// Four instances: 48-bit with latency 3 (main), latency 1, latency 8, and a
// 16-bit one. The main instance also sees random streams with backpressure,
// checked in order against a queue of results from an arithmetic model.
module tb_alu_1_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [24:0] action_in;
  logic [3:0]  av;
  logic [47:0] op1;
  logic [47:0] op2;
  logic        cor;

  logic [47:0] out0, out1, out2;
  logic [15:0] out3;
  logic        vld0, vld1, vld2, vld3;
  logic        rdy0, rdy1, rdy2, rdy3;
  logic        flg0, flg1, flg2, flg3;

  logic [63:0] res_v [4];
  logic [3:0]  vld_v;
  logic [3:0]  flg_v;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic last_accept = 1'b0;
  logic [64:0] sb[$];

  always #5 clk = ~clk;

  alu_1_pipe #(.STAGE(0), .DATA_WIDTH(48), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(av[0]),
    .action_ready(rdy0), .operand_1_in(op1), .operand_2_in(op2),
    .container_out(out0), .container_out_valid(vld0),
    .container_out_ready(cor), .flag_out(flg0));

  alu_1_pipe #(.STAGE(1), .DATA_WIDTH(48), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(av[1]),
    .action_ready(rdy1), .operand_1_in(op1), .operand_2_in(op2),
    .container_out(out1), .container_out_valid(vld1),
    .container_out_ready(1'b1), .flag_out(flg1));

  alu_1_pipe #(.STAGE(2), .DATA_WIDTH(48), .LATENCY(8)) u_lat8 (
    .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(av[2]),
    .action_ready(rdy2), .operand_1_in(op1), .operand_2_in(op2),
    .container_out(out2), .container_out_valid(vld2),
    .container_out_ready(1'b1), .flag_out(flg2));

  alu_1_pipe #(.STAGE(3), .DATA_WIDTH(16), .LATENCY(3)) u_w16 (
    .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(av[3]),
    .action_ready(rdy3), .operand_1_in(op1[15:0]), .operand_2_in(op2[15:0]),
    .container_out(out3), .container_out_valid(vld3),
    .container_out_ready(1'b1), .flag_out(flg3));

  assign res_v[0] = {16'b0, out0};
  assign res_v[1] = {16'b0, out1};
  assign res_v[2] = {16'b0, out2};
  assign res_v[3] = {48'b0, out3};
  assign vld_v    = {vld3, vld2, vld1, vld0};
  assign flg_v    = {flg3, flg2, flg1, flg0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic at width w; returns {flag, result}.
  function automatic logic [64:0] ref_model(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input logic [63:0] imm,
                                            input int w);
    logic [64:0] mask;
    logic [64:0] x;
    logic [64:0] y;
    logic [64:0] r;
    logic        f;
    mask = (65'd1 << w) - 65'd1;
    x = {1'b0, a} & mask;
    y = {1'b0, b} & mask;
    f = 1'b0;
    r = x;
    if (op == 4'd3 || op == 4'd4) y = {1'b0, imm} & mask;
    case (op)
      4'd1, 4'd9, 4'd3: begin r = x + y; f = (r > mask); r = r & mask; end
      4'd2, 4'd10, 4'd4: begin f = (x < y); r = (x - y) & mask; end
      4'd5: r = x & y;
      4'd6: r = x | y;
      4'd7: r = x ^ y;
      4'd11: begin r = x + y; if (r > mask) begin r = mask; f = 1'b1; end end
      4'd12: begin if (x < y) begin r = 65'd0; f = 1'b1; end else r = x - y; end
      default: r = x;
    endcase
    return {f, r[63:0]};
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return 48'hFFFF_FFFF_FFFF - 48'($urandom_range(0, 8));
      1: return 48'($urandom_range(0, 16));
      default: return t[47:0];
    endcase
  endfunction

  // Single action into instance d with ready high; checks latency, value, flag.
  task automatic run_op(input int d, input string tag, input logic [3:0] op,
                        input logic [47:0] a, input logic [47:0] b, input logic [15:0] imm,
                        input logic [47:0] exp_res, input logic exp_flag, input int exp_lat);
    int cyc;
    action_in = {op, 5'b0, imm};
    op1 = a;
    op2 = b;
    cor = 1'b1;
    av = 4'b0;
    av[d] = 1'b1;
    @(posedge clk); #1;
    av = 4'b0;
    cyc = 1;
    while (!vld_v[d] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_res"}, res_v[d], {16'b0, exp_res});
    check({tag, "_flag"}, 64'(flg_v[d]), 64'(exp_flag));
    $display("op %s: dut %0d result 0x%0h flag %0d after %0d cycles", tag, d, res_v[d], flg_v[d], cyc);
    @(posedge clk); #1;
  endtask

  // One cycle of the main instance with the inputs already driven.
  task automatic step();
    logic [64:0] e;
    logic consume;
    logic accept;
    #1;
    check("ready", 64'(rdy0), 64'(!(vld0 && !cor)));
    if (!vld0) check("bubble", {15'b0, flg0, out0}, 64'd0);
    consume = vld0 && cor;
    accept  = av[0] && !(vld0 && !cor);
    if (consume) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("stream_res", {16'b0, out0}, e[63:0]);
        check("stream_flag", 64'(flg0), 64'(e[64]));
        n_out++;
        $display("out #%0d: 0x%0h flag %0d", n_out, out0, flg0);
      end
    end
    if (accept)
      sb.push_back(ref_model(action_in[24:21], {16'b0, op1}, {16'b0, op2},
                             {48'b0, action_in[15:0]}, 48));
    last_accept = accept;
    @(posedge clk); #1;
  endtask

  initial begin
    int idx;
    int cyc;
    rst_n = 1'b0;
    av = 4'b0;
    action_in = '0;
    op1 = '0;
    op2 = '0;
    cor = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_out", res_v[0], 64'd0);
    check("rst_valid", 64'(vld0), 64'd0);
    check("rst_flag", 64'(flg0), 64'd0);
    check("rst_ready", 64'(rdy0), 64'd1);
    @(posedge clk); #1;

    // Directed opcode cases
    run_op(0, "add",   4'b0001, 48'h5, 48'h3, 16'h0, 48'h8, 1'b0, 3);
    run_op(0, "sub",   4'b0010, 48'h1, 48'h2, 16'h0, 48'hFFFF_FFFF_FFFF, 1'b1, 3);
    run_op(0, "sub2",  4'b1010, 48'h9, 48'h4, 16'h0, 48'h5, 1'b0, 3);
    run_op(0, "sadd",  4'b1011, 48'hFFFF_FFFF_FFFE, 48'h5, 16'h0, 48'hFFFF_FFFF_FFFF, 1'b1, 3);
    run_op(0, "ssub",  4'b1100, 48'h3, 48'h7, 16'h0, 48'h0, 1'b1, 3);
    run_op(0, "addi",  4'b0011, 48'h1, 48'h0, 16'h8000, 48'h8001, 1'b0, 3);
    run_op(0, "subi",  4'b0100, 48'h10, 48'h5, 16'h0020, 48'hFFFF_FFFF_FFF0, 1'b1, 3);
    run_op(0, "pass",  4'b1111, 48'hABC, 48'h123, 16'h0, 48'hABC, 1'b0, 3);
    run_op(0, "xor",   4'b0111, 48'hF0, 48'hFF, 16'h0, 48'h0F, 1'b0, 3);
    run_op(0, "and",   4'b0101, 48'hF0, 48'h3C, 16'h0, 48'h30, 1'b0, 3);
    run_op(0, "or",    4'b0110, 48'hF0, 48'h0F, 16'h0, 48'hFF, 1'b0, 3);
    run_op(0, "carry", 4'b1001, 48'hFFFF_FFFF_FFFF, 48'h1, 16'h0, 48'h0, 1'b1, 3);
    run_op(1, "lat1",  4'b0001, 48'h5, 48'h3, 16'h0, 48'h8, 1'b0, 1);
    run_op(2, "lat8",  4'b0001, 48'h5, 48'h3, 16'h0, 48'h8, 1'b0, 8);
    run_op(3, "w16",   4'b0001, 48'hFFFF, 48'h1, 16'h0, 48'h0, 1'b1, 3);

    // Six back-to-back adds, output not ready on cycles 4-6
    n_out = 0;
    idx = 0;
    cyc = 0;
    while ((idx < 6 || sb.size() > 0) && cyc < 40) begin
      av[0] = (idx < 6);
      action_in = {4'b0001, 21'b0};
      op1 = 48'h1000 + 48'(idx);
      op2 = 48'(idx);
      cor = !(cyc >= 4 && cyc <= 6);
      step();
      if (last_accept) idx++;
      cyc++;
    end
    check("six_count", 64'(n_out), 64'd6);
    check("six_empty", 64'(sb.size()), 64'd0);

    // Random stream with random valid and backpressure
    av = 4'b0;
    last_accept = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(av[0] && !last_accept)) begin
        av[0] = ($urandom_range(0, 3) != 0);
        action_in = {4'($urandom_range(0, 15)), 5'($urandom), 16'($urandom)};
        op1 = rand48();
        op2 = rand48();
      end
      cor = ($urandom_range(0, 3) != 0);
      step();
    end
    av[0] = 1'b0;
    cor = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) step();
    check("drain_empty", 64'(sb.size()), 64'd0);

    // Reset with three results in flight
    cor = 1'b1;
    action_in = {4'b0001, 21'b0};
    op1 = 48'h77;
    op2 = 48'h1;
    av[0] = 1'b1;
    repeat (3) step();
    av[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(vld0), 64'd0);
    check("midrst_out", res_v[0], 64'd0);
    check("midrst_flag", 64'(flg0), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("postrst_valid", 64'(vld0), 64'd0);
      check("postrst_ready", 64'(rdy0), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_1_pipe.md
Name: alu_1_pipe

Overview:
Parametrised successor to the stage-level type-1 ALU (no load/store). Computes one PHV container result per accepted action, with:
- an extended op set: immediate, logic and saturating ops;
- configurable pipeline latency;
- valid/ready backpressure and a carry/borrow flag.

It sits between the sub_action decoder and PHV re-assembly in each RMT stage.

Parameters:
STAGE, 0, stage index (informational, no functional effect)
ACTION_LEN, 25, action word width; opcode at [24:21]
DATA_WIDTH, 48, operand/result width (legal: 16, 32, 48)
IMM_WIDTH, 16, immediate width taken from action_in[IMM_WIDTH-1:0]; must be <= DATA_WIDTH and <= 21
LATENCY, 3, cycles from accept to output valid; legal 1..8

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
action_in  in  ACTION_LEN  action word from sub_action
action_valid  in  1  action and operands valid this cycle
action_ready  out  1  block can accept this cycle
operand_1_in  in  DATA_WIDTH  first operand (PHV container)
operand_2_in  in  DATA_WIDTH  second operand (PHV container)
container_out  out  DATA_WIDTH  result
container_out_valid  out  1  result valid
container_out_ready  in  1  downstream accepts result
flag_out  out  1  carry (add-type) or borrow (sub-type) of the result; 0 for other ops

Behaviour:
Reset:
- rst_n low (asynchronous) clears all pipeline valid bits, data and flags.
- container_out=0, container_out_valid=0, flag_out=0.
- action_ready=1 one cycle after deassertion.
- Reset mid-operation discards all in-flight results; nothing is replayed.

Handshake:
- Accept when action_valid & action_ready.
- stall = container_out_valid & ~container_out_ready.
- action_ready = ~stall (combinational).
- While stall is high the whole pipeline freezes: all stage registers hold, including bubbles.
- Output is consumed when container_out_valid & container_out_ready.
- action_valid while ~action_ready: the action is ignored. Upstream must hold it.

Latency:
- Result computed combinationally at stage 0, registered, then shifted through LATENCY-1 further register stages.
- With no stall, an action accepted on edge N gives container_out_valid on edge N+LATENCY.
- Each stall cycle adds one cycle to the latency.
- Cycles with no accept inject bubbles: valid=0, data=0.

Opcode (action_in[24:21]); imm = action_in[IMM_WIDTH-1:0] zero-extended to DATA_WIDTH:
- 0001, 1001 add: op1+op2; flag=carry out.
- 0010, 1010 sub: op1-op2 modulo 2^DATA_WIDTH; flag=borrow (op1<op2).
- 0011 addi: op1+imm; flag=carry.
- 0100 subi: op1-imm; flag=borrow.
- 0101 and, 0110 or, 0111 xor: bitwise op1/op2; flag=0.
- 1011 sadd: op1+op2 unsigned, clamped to all-ones on carry; flag=1 if clamped.
- 1100 ssub: op1-op2 unsigned, clamped to 0 on borrow; flag=1 if clamped.
- All others, including 0000: pass op1 unchanged; flag=0. Result is still valid.

Arithmetic is unsigned and DATA_WIDTH bits wide. The flag is bit DATA_WIDTH of an extended (DATA_WIDTH+1)-bit add/sub.

Boundaries:
- Back-to-back accepts every cycle give full throughput, one result per cycle, in order.
- A stall with bubbles inside the pipeline does not compress them. This is accepted.
- container_out_ready low while container_out_valid=0 does not stall.

Test Plan:
- DATA_WIDTH=48, LATENCY=3: add op1=0x0000_0000_0005, op2=0x3 accepted cycle 0 -> container_out=0x8, valid on edge 3, flag=0.
- sub op1=0x1, op2=0x2 -> 0xFFFF_FFFF_FFFF, flag=1. sadd op1=0xFFFF_FFFF_FFFE, op2=0x5 -> 0xFFFF_FFFF_FFFF, flag=1. ssub 0x3-0x7 -> 0, flag=1.
- addi with action_in[15:0]=0x8000, op1=0x1 -> 0x8001. Opcode 1111, op1=0xABC -> 0xABC, flag=0. xor 0xF0^0xFF -> 0x0F.
- Stream 6 adds back-to-back, container_out_ready=0 for cycles 4-6:
  - action_ready low on exactly the cycles container_out_valid=1 and container_out_ready=0;
  - all 6 results arrive in order, none lost or duplicated.
- Assert rst_n low for 1 cycle with 3 results in flight -> container_out_valid=0 immediately; no stale result emerges afterwards.
- Repeat the first case with LATENCY=1 and LATENCY=8, and with DATA_WIDTH=16 (0xFFFF+0x1 -> 0x0000, flag=1) -> latency and width exactly as configured.
